mem_write_checker: RTL and testbench

- Synthesizable, parametrised self-check monitor for the pipelined processor's data-memory write port (MemWriteM / DataAdrM / WriteDataM).
- Replaces the single hard-coded "address 14" success check with a loadable table of up to NUM_CHECKS expected (address, data) writes, a cycle timeout, and strict or subsequence match modes.
- Sits beside top in benches; can also be placed on-chip as a built-in self-test (BIST) status block.

---
 rtl/mwc_pkg.sv | 17 +
 rtl/mwc_exp_table.sv | 38 +++
 rtl/mem_write_checker.sv | 125 ++++++++++++
 tb/tb_mem_write_checker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mwc_pkg.sv
// rtl/mwc_pkg.sv - shared state encoding and sizing helper for mem_write_checker
package mwc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } mwcState_t;

    // Index width for a table of the given depth, never narrower than one bit
    function automatic int idxWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// rtl/mwc_exp_table.sv - expected {address, data} table, one sync write port, one comb read port
module mwc_exp_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHECKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wrIdx,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [IDX_W:0]        rdIdx,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [ADDR_WIDTH-1:0] addrMem [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] dataMem [NUM_CHECKS];

    // Deliberately not reset: a loaded table survives a checker reset
    always_ff @(posedge clk) begin
        if (we && int'(wrIdx) < NUM_CHECKS) begin
            addrMem[wrIdx] <= wrAddr;
            dataMem[wrIdx] <= wrData;
        end
    end

    always_comb begin
        rdAddr = '0;
        rdData = '0;
        if (int'(rdIdx) < NUM_CHECKS) begin
            rdAddr = addrMem[rdIdx[IDX_W-1:0]];
            rdData = dataMem[rdIdx[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - table-driven monitor of the data-memory write port with timeout
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_WIDTH      = 16,
    localparam int IDX_W         = idxWidth(NUM_CHECKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic [IDX_W:0]        cfg_len,
    input  logic                  cfg_strict,
    input  logic                  start,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] DataAdrM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [IDX_W:0]        match_count,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    localparam logic [IDX_W:0]       FULL_LEN   = (IDX_W+1)'(NUM_CHECKS);
    localparam logic [IDX_W:0]       ONE_IDX    = (IDX_W+1)'(1);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    mwcState_t             state;
    mwcState_t             nextState;
    logic [IDX_W:0]        lenQ;
    logic                  strictQ;
    logic [ADDR_WIDTH-1:0] expAddr;
    logic [DATA_WIDTH-1:0] expData;
    logic                  hit;
    logic                  finalHit;
    logic                  strictMiss;
    logic [IDX_W:0]        nextMatch;

    mwc_exp_table #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_CHECKS(NUM_CHECKS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we && state == IDLE),
        .wrIdx (cfg_idx),
        .wrAddr(cfg_addr),
        .wrData(cfg_data),
        .rdIdx (match_count),
        .rdAddr(expAddr),
        .rdData(expData)
    );

    assign hit        = MemWriteM && DataAdrM == expAddr && WriteDataM == expData;
    assign nextMatch  = match_count + ONE_IDX;
    assign finalHit   = hit && nextMatch == lenQ;
    assign strictMiss = MemWriteM && !hit && strictQ;

    // Same-edge priority is PASS, then FAIL, then TIMEOUT
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = RUN;
            RUN: begin
                if (finalHit)                       nextState = PASS;
                else if (strictMiss)                nextState = FAIL;
                else if (cycle_count == LAST_CYCLE) nextState = TIMEOUT;
            end
            default: if (start) nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lenQ        <= '0;
            strictQ     <= 1'b0;
            match_count <= '0;
            cycle_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state   <= nextState;
            busy    <= nextState == RUN;
            done    <= nextState == PASS || nextState == FAIL || nextState == TIMEOUT;
            pass    <= nextState == PASS;
            fail    <= nextState == FAIL;
            timeout <= nextState == TIMEOUT;
            if (state != RUN && nextState == RUN) begin
                lenQ        <= (cfg_len == '0 || cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
                strictQ     <= cfg_strict;
                match_count <= '0;
                cycle_count <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
            end else if (state == RUN) begin
                if (cycle_count != LAST_CYCLE) cycle_count <= cycle_count + ONE_CNT;
                if (hit) match_count <= nextMatch;
                if (nextState == FAIL) begin
                    fail_addr <= DataAdrM;
                    fail_data <= WriteDataM;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - scoreboard bench for mem_write_checker
module tb_mem_write_checker;

    localparam int T     = 10;
    localparam int NCYC  = 12;

    logic        clk = 1'b0;
    logic        reset, cfg_we, cfg_strict, start, MemWriteM;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_addr, cfg_data, DataAdrM, WriteDataM;
    logic [3:0]  cfg_len;
    logic        busy, done, pass, fail, timeout;
    logic [3:0]  match_count;
    logic [15:0] cycle_count;
    logic [31:0] fail_addr, fail_data;

    always #5 clk = ~clk;

    mem_write_checker #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .cfg_strict(cfg_strict), .start(start), .MemWriteM(MemWriteM),
        .DataAdrM(DataAdrM), .WriteDataM(WriteDataM), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .match_count(match_count),
        .cycle_count(cycle_count), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    // cw: during the cycle, also attempt a table write of entry 1 = (18, 99)
    typedef struct { logic we; logic [31:0] a; logic [31:0] d; logic cw; } stimT;
    typedef struct { logic [2:0] flags; logic [3:0] mc; logic [15:0] cc; logic [31:0] fa; logic [31:0] fd; } expT;

    stimT        stimQ[$];
    expT         expQ[$];
    logic [31:0] tblA [8];
    logic [31:0] tblD [8];
    int          checks = 0;
    int          passes = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic addW(input logic we, input logic [31:0] a, input logic [31:0] d, input logic cw);
        stimT s;
        s.we = we; s.a = a; s.d = d; s.cw = cw;
        stimQ.push_back(s);
    endtask

    task automatic cycleIn(input stimT s);
        MemWriteM = s.we; DataAdrM = s.a; WriteDataM = s.d;
        cfg_we = s.cw; cfg_idx = 3'd1; cfg_addr = 32'd18; cfg_data = 32'd99;
        @(negedge clk);
        MemWriteM = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        tblA[idx] = a; tblD[idx] = d;
    endtask

    task automatic pushExp(input logic [2:0] flags, input int mc, input int cc, input logic [31:0] fa, input logic [31:0] fd);
        expT e;
        e.flags = flags; e.mc = 4'(mc); e.cc = 16'(cc); e.fa = fa; e.fd = fd;
        expQ.push_back(e);
    endtask

    task automatic runScenario(input string name, input int len, input logic strict);
        int   mMatch, mCc;
        bit   decided, seen, h, last;
        stimT s;
        expT  e;
        mMatch = 0; mCc = 0; decided = 0; seen = 0;
        cfg_len = 4'(len); cfg_strict = strict; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (stimQ.size() < NCYC) addW(1'b0, 32'd0, 32'd0, 1'b0);
        for (int k = 0; k < NCYC; k++) begin
            s = stimQ[k];
            if (!decided) begin
                h    = s.we && s.a == tblA[mMatch] && s.d == tblD[mMatch];
                last = (mCc == T - 1);
                if (!last) mCc++;
                if (h) mMatch++;
                if (h && mMatch == len) begin
                    pushExp(3'b100, mMatch, mCc, 32'd0, 32'd0); decided = 1;
                end else if (s.we && !h && strict) begin
                    pushExp(3'b010, mMatch, mCc, s.a, s.d); decided = 1;
                end else if (last) begin
                    pushExp(3'b001, mMatch, mCc, 32'd0, 32'd0); decided = 1;
                end
            end
            cycleIn(s);
            checkVal({name, ":done"}, 32'(done), 32'(decided));
            checkVal({name, ":busy"}, 32'(busy), 32'(!decided));
            if (done && !seen) begin
                seen = 1;
                if (expQ.size() == 0) begin
                    checkVal({name, ":unexpectedDone"}, 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkVal({name, ":pass_fail_timeout"}, 32'({pass, fail, timeout}), 32'(e.flags));
                    checkVal({name, ":match_count"}, 32'(match_count), 32'(e.mc));
                    checkVal({name, ":cycle_count"}, 32'(cycle_count), 32'(e.cc));
                    checkVal({name, ":fail_addr"}, fail_addr, e.fa);
                    checkVal({name, ":fail_data"}, fail_data, e.fd);
                end
            end
        end
        if (seen) checkVal({name, ":ccFrozen"}, 32'(cycle_count), 32'(e.cc));
        else      checkVal({name, ":doneSeen"}, 32'd0, 32'd1);
        expQ.delete();
        stimQ.delete();
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        cfg_len = '0; cfg_strict = 1'b0; start = 1'b0;
        MemWriteM = 1'b0; DataAdrM = '0; WriteDataM = '0;
        for (int i = 0; i < 8; i++) begin tblA[i] = 32'hFFFF_FFFF; tblD[i] = 32'hFFFF_FFFF; end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        checkVal("reset:flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
        checkVal("reset:counts", 32'({match_count, cycle_count}), 32'd0);

        loadEntry(0, 32'd14, 32'd7);
        loadEntry(1, 32'd18, 32'd3);

        addW(1, 14, 7, 0); addW(1, 18, 3, 0);
        runScenario("strictPass", 2, 1'b1);

        addW(1, 14, 7, 0); addW(1, 20, 9, 0);
        runScenario("strictFail", 2, 1'b1);

        addW(1, 14, 7, 0); addW(1, 20, 9, 0); addW(1, 18, 3, 0);
        runScenario("subseqPass", 2, 1'b0);

        runScenario("timeout", 2, 1'b1);

        addW(1, 14, 7, 0);
        for (int i = 0; i < 8; i++) addW(0, 0, 0, 0);
        addW(1, 18, 3, 0);
        runScenario("finalOnLastCycle", 2, 1'b1);

        // Abort a run with reset after one match, then rerun on the untouched table
        cfg_len = 4'd2; cfg_strict = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addW(1, 14, 7, 0);
        cycleIn(stimQ.pop_front());
        checkVal("midRun:match_count", 32'(match_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("midRun:flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
        checkVal("midRun:counts", 32'({match_count, cycle_count}), 32'd0);
        checkVal("midRun:captures", fail_addr | fail_data, 32'd0);
        addW(1, 14, 7, 0); addW(1, 18, 3, 0);
        runScenario("afterReset", 2, 1'b1);

        addW(0, 0, 0, 1); addW(1, 14, 7, 0); addW(1, 18, 3, 0);
        runScenario("cfgWeInRun", 2, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
